dm_access_ctrl: RTL and testbench

- Sequencer/arbiter in front of the single-port, word-wide data memory.
- Shares the memory between the CPU MEM stage (full MIPS load/store op set) and a word-only DMA/loader port.
- Performs read-modify-write for sb/sh, and byte/halfword extraction with sign/zero extension for lb/lbu/lh/lhu.
- Drives Cpu_Stall_Out so the pipeline freezes while a CPU access is in flight.

---
 rtl/dm_access_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// Sequencer/arbiter sharing one single-port word-wide data memory between the CPU
// MEM stage (full load/store op set, sb/sh via read-modify-write) and a word-only DMA port.
module dm_access_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cpu_Req_In,
  input  logic [5:0]        Cpu_Op_In,
  input  logic [31:0]       Cpu_Addr_In,
  input  logic [31:0]       Cpu_Wdata_In,
  output logic [31:0]       Cpu_Rdata_Out,
  output logic              Cpu_Ack_Out,
  output logic              Cpu_Stall_Out,
  input  logic              Dma_Req_In,
  input  logic              Dma_We_In,
  input  logic [31:0]       Dma_Addr_In,
  input  logic [31:0]       Dma_Wdata_In,
  output logic [31:0]       Dma_Rdata_Out,
  output logic              Dma_Ack_Out,
  output logic              Mem_En_Out,
  output logic              Mem_We_Out,
  output logic [ADDR_W-1:0] Mem_Addr_Out,
  output logic [31:0]       Mem_Wdata_Out,
  input  logic [31:0]       Mem_Rdata_In
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_MERGE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             owner_r;       // 1 = DMA owns the access in flight
  logic [5:0]       op_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      rd_r;
  logic [31:0]      cpu_rdata_r;
  logic [31:0]      dma_rdata_r;
  logic [CNT_W-1:0] starve_cnt_r;
  logic             dma_grant_s;
  logic             mem_en_s;
  logic             mem_we_s;
  logic [31:0]      mem_wdata_s;
  logic             cpu_ack_s;
  logic             dma_ack_s;
  logic             unused_s;

  function automatic logic needs_read(input logic [5:0] op);
    case (op)
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH: needs_read = 1'b1;
      default:                                           needs_read = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LW:   load_extract = word;
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'h000000, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'h0000, h};
      default: load_extract = 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [5:0] op, input logic [1:0] lane,
                                              input logic [31:0] rd, input logic [31:0] wd);
    merge_store = rd;
    case (op)
      OP_SB: begin
        case (lane)
          2'b00:   merge_store[7:0]   = wd[7:0];
          2'b01:   merge_store[15:8]  = wd[7:0];
          2'b10:   merge_store[23:16] = wd[7:0];
          2'b11:   merge_store[31:24] = wd[7:0];
          default: merge_store[7:0]   = wd[7:0];
        endcase
      end
      OP_SH: begin
        if (lane[1]) merge_store[31:16] = wd[15:0];
        else         merge_store[15:0]  = wd[15:0];
      end
      default: merge_store = rd;
    endcase
  endfunction

  // DMA wins when the CPU is idle or has already taken STARVE_LIMIT grants in a row.
  assign dma_grant_s = Dma_Req_In && (!Cpu_Req_In || (starve_cnt_r == CNT_W'(STARVE_LIMIT)));

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_r <= S_IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Cpu_Req_In || Dma_Req_In) state_next_s = S_ISSUE;
        else                          state_next_s = S_IDLE;
      end
      S_ISSUE: begin
        if (needs_read(op_r)) state_next_s = S_WAIT;
        else                  state_next_s = S_DONE;
      end
      S_WAIT: begin
        if ((op_r == OP_SB) || (op_r == OP_SH)) state_next_s = S_MERGE;
        else                                    state_next_s = S_DONE;
      end
      S_MERGE: state_next_s = S_DONE;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Arbitration and request latch; DMA requests are mapped onto lw/sw
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      owner_r      <= 1'b0;
      op_r         <= 6'b000000;
      addr_r       <= 32'h00000000;
      wdata_r      <= 32'h00000000;
      starve_cnt_r <= '0;
    end else if (state_r == S_IDLE) begin
      if (dma_grant_s) begin
        owner_r <= 1'b1;
        op_r    <= Dma_We_In ? OP_SW : OP_LW;
        addr_r  <= {Dma_Addr_In[31:2], 2'b00};
        wdata_r <= Dma_Wdata_In;
      end else if (Cpu_Req_In) begin
        owner_r <= 1'b0;
        op_r    <= Cpu_Op_In;
        addr_r  <= Cpu_Addr_In;
        wdata_r <= Cpu_Wdata_In;
      end
      if (!Dma_Req_In || dma_grant_s) starve_cnt_r <= '0;
      else if (Cpu_Req_In)            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end
  end

  // Read word capture and registered load results
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_r        <= 32'h00000000;
      cpu_rdata_r <= 32'h00000000;
      dma_rdata_r <= 32'h00000000;
    end else if (state_r == S_WAIT) begin
      rd_r <= Mem_Rdata_In;
      if (state_next_s == S_DONE) begin
        if (owner_r) dma_rdata_r <= Mem_Rdata_In;
        else         cpu_rdata_r <= load_extract(op_r, addr_r[1:0], Mem_Rdata_In);
      end
    end
  end

  // Moore output decode
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_wdata_s = 32'h00000000;
    cpu_ack_s   = 1'b0;
    dma_ack_s   = 1'b0;
    case (state_r)
      S_ISSUE: begin
        if (op_r == OP_SW) begin
          mem_en_s    = 1'b1;
          mem_we_s    = 1'b1;
          mem_wdata_s = wdata_r;
        end else if (needs_read(op_r)) begin
          mem_en_s = 1'b1;
        end else begin
          mem_en_s = 1'b0;
        end
      end
      S_MERGE: begin
        mem_en_s    = 1'b1;
        mem_we_s    = 1'b1;
        mem_wdata_s = merge_store(op_r, addr_r[1:0], rd_r, wdata_r);
      end
      S_DONE: begin
        cpu_ack_s = !owner_r;
        dma_ack_s = owner_r;
      end
      default: mem_en_s = 1'b0;
    endcase
  end

  assign Mem_En_Out    = mem_en_s;
  assign Mem_We_Out    = mem_we_s;
  assign Mem_Wdata_Out = mem_wdata_s;
  assign Mem_Addr_Out  = addr_r[ADDR_W+1:2];
  assign Cpu_Ack_Out   = cpu_ack_s;
  assign Dma_Ack_Out   = dma_ack_s;
  assign Cpu_Rdata_Out = cpu_rdata_r;
  assign Dma_Rdata_Out = dma_rdata_r;
  assign Cpu_Stall_Out = Cpu_Req_In && !cpu_ack_s;
  assign unused_s      = ^addr_r[31:ADDR_W+2];

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl with a behavioural synchronous memory.
module tb_dm_access_ctrl;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;

  logic        Clk;
  logic        Reset;
  logic        Cpu_Req_In;
  logic [5:0]  Cpu_Op_In;
  logic [31:0] Cpu_Addr_In;
  logic [31:0] Cpu_Wdata_In;
  logic [31:0] Cpu_Rdata_Out;
  logic        Cpu_Ack_Out;
  logic        Cpu_Stall_Out;
  logic        Dma_Req_In;
  logic        Dma_We_In;
  logic [31:0] Dma_Addr_In;
  logic [31:0] Dma_Wdata_In;
  logic [31:0] Dma_Rdata_Out;
  logic        Dma_Ack_Out;
  logic        Mem_En_Out;
  logic        Mem_We_Out;
  logic [11:0] Mem_Addr_Out;
  logic [31:0] Mem_Wdata_Out;
  logic [31:0] Mem_Rdata_In;

  logic [31:0] mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];
  int          own_q[$];
  logic [31:0] last_cpu;

  dm_access_ctrl #(.ADDR_W(12), .STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .Cpu_Req_In(Cpu_Req_In), .Cpu_Op_In(Cpu_Op_In), .Cpu_Addr_In(Cpu_Addr_In),
    .Cpu_Wdata_In(Cpu_Wdata_In), .Cpu_Rdata_Out(Cpu_Rdata_Out), .Cpu_Ack_Out(Cpu_Ack_Out),
    .Cpu_Stall_Out(Cpu_Stall_Out),
    .Dma_Req_In(Dma_Req_In), .Dma_We_In(Dma_We_In), .Dma_Addr_In(Dma_Addr_In),
    .Dma_Wdata_In(Dma_Wdata_In), .Dma_Rdata_Out(Dma_Rdata_Out), .Dma_Ack_Out(Dma_Ack_Out),
    .Mem_En_Out(Mem_En_Out), .Mem_We_Out(Mem_We_Out), .Mem_Addr_Out(Mem_Addr_Out),
    .Mem_Wdata_Out(Mem_Wdata_Out), .Mem_Rdata_In(Mem_Rdata_In)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single-port memory: one-cycle read latency, word writes, plus a bench preload path.
  always @(posedge Clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (Mem_En_Out && Mem_We_Out) mem[Mem_Addr_Out] <= Mem_Wdata_Out;
    if (Mem_En_Out && !Mem_We_Out) Mem_Rdata_In <= mem[Mem_Addr_Out];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge Clk);
    @(negedge Clk);
    pre_en = 1'b0;
  endtask

  // Called at a negedge with the controller idle; lat = cycles from request to Ack inclusive.
  task automatic cpu_xact(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output int lat);
    Cpu_Op_In = op; Cpu_Addr_In = a; Cpu_Wdata_In = wd; Cpu_Req_In = 1'b1;
    lat = 1;
    while (lat < 30) begin
      @(posedge Clk);
      @(negedge Clk);
      lat++;
      if (Cpu_Ack_Out) break;
    end
    Cpu_Req_In = 1'b0;
    @(negedge Clk);
  endtask

  task automatic dma_xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int lat);
    Dma_We_In = we; Dma_Addr_In = a; Dma_Wdata_In = wd; Dma_Req_In = 1'b1;
    lat = 1;
    while (lat < 30) begin
      @(posedge Clk);
      @(negedge Clk);
      lat++;
      if (Dma_Ack_Out) break;
    end
    Dma_Req_In = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (Mem_En_Out !== 1'b0 || Mem_We_Out !== 1'b0) begin errors++;
      $display("FAIL reset_mem_en_we: got %b%b want 00", Mem_En_Out, Mem_We_Out); end
    checks++; if (Mem_Addr_Out !== 12'h000 || Mem_Wdata_Out !== 32'h0) begin errors++;
      $display("FAIL reset_mem_addr_wdata: got %h %h want 0 0", Mem_Addr_Out, Mem_Wdata_Out); end
    checks++; if (Cpu_Ack_Out !== 1'b0 || Dma_Ack_Out !== 1'b0) begin errors++;
      $display("FAIL reset_acks: got %b%b want 00", Cpu_Ack_Out, Dma_Ack_Out); end
    checks++; if (Cpu_Rdata_Out !== 32'h0 || Dma_Rdata_Out !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h %h want 0 0", Cpu_Rdata_Out, Dma_Rdata_Out); end
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (Mem_En_Out !== 1'b0 || Cpu_Stall_Out !== 1'b0) begin errors++;
      $display("FAIL idle_after_reset: got en=%b stall=%b want 0 0", Mem_En_Out, Cpu_Stall_Out); end
    last_cpu = 32'h0;
  endtask

  task automatic test_sw_timing();
    Cpu_Op_In = SW; Cpu_Addr_In = 32'h10; Cpu_Wdata_In = 32'h12345678; Cpu_Req_In = 1'b1;
    #1;
    checks++; if (Cpu_Stall_Out !== 1'b1 || Mem_En_Out !== 1'b0) begin errors++;
      $display("FAIL sw_cycle1: got stall=%b en=%b want 1 0", Cpu_Stall_Out, Mem_En_Out); end
    @(posedge Clk); @(negedge Clk);
    checks++; if (Mem_En_Out !== 1'b1 || Mem_We_Out !== 1'b1) begin errors++;
      $display("FAIL sw_cycle2_en_we: got %b%b want 11", Mem_En_Out, Mem_We_Out); end
    checks++; if (Mem_Addr_Out !== 12'd4 || Mem_Wdata_Out !== 32'h12345678) begin errors++;
      $display("FAIL sw_cycle2_addr_data: got %h %h want 004 12345678", Mem_Addr_Out, Mem_Wdata_Out); end
    checks++; if (Cpu_Stall_Out !== 1'b1 || Cpu_Ack_Out !== 1'b0) begin errors++;
      $display("FAIL sw_cycle2_stall_ack: got %b %b want 1 0", Cpu_Stall_Out, Cpu_Ack_Out); end
    @(posedge Clk); @(negedge Clk);
    checks++; if (Cpu_Ack_Out !== 1'b1 || Cpu_Stall_Out !== 1'b0) begin errors++;
      $display("FAIL sw_cycle3_ack_stall: got %b %b want 1 0", Cpu_Ack_Out, Cpu_Stall_Out); end
    checks++; if (Mem_En_Out !== 1'b0 || Dma_Ack_Out !== 1'b0) begin errors++;
      $display("FAIL sw_cycle3_en_dack: got %b %b want 0 0", Mem_En_Out, Dma_Ack_Out); end
    Cpu_Req_In = 1'b0;
    @(negedge Clk);
    checks++; if (mem[4] !== 32'h12345678) begin errors++;
      $display("FAIL sw_mem_word: got %h want 12345678", mem[4]); end
  endtask

  task automatic test_byte();
    int lat;
    logic [31:0] e;
    cpu_xact(SB, 32'h11, 32'hFFFFFFAB, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sb_latency: got %0d want 5", lat); end
    checks++; if (mem[4] !== 32'h1234AB78) begin errors++;
      $display("FAIL sb_mem_word: got %h want 1234ab78", mem[4]); end
    checks++; if (Cpu_Rdata_Out !== last_cpu) begin errors++;
      $display("FAIL sb_rdata_kept: got %h want %h", Cpu_Rdata_Out, last_cpu); end
    exp_q.push_back(32'hFFFFFFAB);
    cpu_xact(LB, 32'h11, 32'h0, lat);
    e = exp_q.pop_front(); last_cpu = e;
    checks++; if (lat !== 4) begin errors++; $display("FAIL lb_latency: got %0d want 4", lat); end
    checks++; if (Cpu_Rdata_Out !== e) begin errors++;
      $display("FAIL lb_rdata: got %h want %h", Cpu_Rdata_Out, e); end
    exp_q.push_back(32'h000000AB);
    cpu_xact(LBU, 32'h11, 32'h0, lat);
    e = exp_q.pop_front(); last_cpu = e;
    checks++; if (Cpu_Rdata_Out !== e) begin errors++;
      $display("FAIL lbu_rdata: got %h want %h", Cpu_Rdata_Out, e); end
    exp_q.push_back(32'h1234AB78);
    cpu_xact(LW, 32'h13, 32'h0, lat);
    e = exp_q.pop_front(); last_cpu = e;
    checks++; if (Cpu_Rdata_Out !== e) begin errors++;
      $display("FAIL lw_unaligned_rdata: got %h want %h", Cpu_Rdata_Out, e); end
  endtask

  task automatic test_half();
    int lat;
    logic [31:0] e;
    preload(12'd4, 32'h8001FFFF);
    exp_q.push_back(32'hFFFF8001);
    exp_q.push_back(32'h00008001);
    exp_q.push_back(32'hFFFFFFFF);
    cpu_xact(LH, 32'h12, 32'h0, lat);
    e = exp_q.pop_front(); last_cpu = e;
    checks++; if (Cpu_Rdata_Out !== e) begin errors++;
      $display("FAIL lh_upper_rdata: got %h want %h", Cpu_Rdata_Out, e); end
    cpu_xact(LHU, 32'h12, 32'h0, lat);
    e = exp_q.pop_front(); last_cpu = e;
    checks++; if (Cpu_Rdata_Out !== e) begin errors++;
      $display("FAIL lhu_upper_rdata: got %h want %h", Cpu_Rdata_Out, e); end
    cpu_xact(LH, 32'h10, 32'h0, lat);
    e = exp_q.pop_front(); last_cpu = e;
    checks++; if (Cpu_Rdata_Out !== e) begin errors++;
      $display("FAIL lh_lower_rdata: got %h want %h", Cpu_Rdata_Out, e); end
    cpu_xact(SH, 32'h12, 32'h0000BEEF, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sh_latency: got %0d want 5", lat); end
    checks++; if (mem[4] !== 32'hBEEFFFFF) begin errors++;
      $display("FAIL sh_mem_word: got %h want beefffff", mem[4]); end
    cpu_xact(SH, 32'h11, 32'h00001234, lat);
    checks++; if (mem[4] !== 32'hBEEF1234) begin errors++;
      $display("FAIL sh_low_lane_mem_word: got %h want beef1234", mem[4]); end
  endtask

  task automatic test_dma();
    int lat;
    logic [31:0] e;
    dma_xact(1'b1, 32'h40, 32'hCAFEF00D, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL dma_wr_latency: got %0d want 3", lat); end
    checks++; if (mem[16] !== 32'hCAFEF00D) begin errors++;
      $display("FAIL dma_wr_mem_word: got %h want cafef00d", mem[16]); end
    exp_q.push_back(32'hCAFEF00D);
    dma_xact(1'b0, 32'h43, 32'h0, lat);
    e = exp_q.pop_front();
    checks++; if (lat !== 4) begin errors++; $display("FAIL dma_rd_latency: got %0d want 4", lat); end
    checks++; if (Dma_Rdata_Out !== e) begin errors++;
      $display("FAIL dma_rd_rdata: got %h want %h", Dma_Rdata_Out, e); end
    checks++; if (Cpu_Rdata_Out !== last_cpu) begin errors++;
      $display("FAIL dma_cpu_rdata_kept: got %h want %h", Cpu_Rdata_Out, last_cpu); end
  endtask

  task automatic test_starvation();
    int cyc;
    int got;
    int want;
    preload(12'd2, 32'h5A5A5A5A);
    preload(12'd32, 32'h0F0F0F0F);
    for (int g = 0; g < 10; g++) own_q.push_back(((g % 5) == 4) ? 1 : 0);
    Cpu_Op_In = LW; Cpu_Addr_In = 32'h08; Cpu_Req_In = 1'b1;
    Dma_We_In = 1'b0; Dma_Addr_In = 32'h80; Dma_Req_In = 1'b1;
    cyc = 0;
    while (own_q.size() > 0 && cyc < 200) begin
      @(posedge Clk); @(negedge Clk);
      cyc++;
      if (Cpu_Ack_Out || Dma_Ack_Out) begin
        got = Dma_Ack_Out ? 1 : 0;
        want = own_q.pop_front();
        checks++; if (got !== want || (Cpu_Ack_Out && Dma_Ack_Out)) begin errors++;
          $display("FAIL starve_grant_order: got owner %0d (cpu_ack=%b dma_ack=%b) want owner %0d",
                   got, Cpu_Ack_Out, Dma_Ack_Out, want); end
      end
    end
    Cpu_Req_In = 1'b0; Dma_Req_In = 1'b0;
    checks++; if (own_q.size() != 0) begin errors++;
      $display("FAIL starve_timeout: got %0d grants outstanding want 0", own_q.size()); end
    own_q.delete();
    @(negedge Clk);
    checks++; if (Dma_Rdata_Out !== 32'h0F0F0F0F || Cpu_Rdata_Out !== 32'h5A5A5A5A) begin errors++;
      $display("FAIL starve_rdata: got %h %h want 5a5a5a5a 0f0f0f0f", Cpu_Rdata_Out, Dma_Rdata_Out); end
    last_cpu = 32'h5A5A5A5A;
  endtask

  task automatic test_input_hold();
    int cyc;
    Cpu_Op_In = SW; Cpu_Addr_In = 32'h20; Cpu_Wdata_In = 32'h0BADF00D; Cpu_Req_In = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Cpu_Op_In = LB; Cpu_Addr_In = 32'h24; Cpu_Wdata_In = 32'hFFFFFFFF;
    cyc = 0;
    while (!Cpu_Ack_Out && cyc < 20) begin @(posedge Clk); @(negedge Clk); cyc++; end
    Cpu_Req_In = 1'b0;
    @(negedge Clk);
    checks++; if (mem[8] !== 32'h0BADF00D || cyc != 1) begin errors++;
      $display("FAIL hold_inputs: got mem %h after %0d cycles want 0badf00d after 1", mem[8], cyc); end
  endtask

  task automatic test_reset_in_merge();
    int lat;
    preload(12'd4, 32'h11223344);
    Cpu_Op_In = SB; Cpu_Addr_In = 32'h10; Cpu_Wdata_In = 32'h00000055; Cpu_Req_In = 1'b1;
    repeat (3) begin @(posedge Clk); @(negedge Clk); end
    checks++; if (Mem_We_Out !== 1'b1 || Mem_Wdata_Out !== 32'h11223355) begin errors++;
      $display("FAIL merge_reached: got we=%b data=%h want 1 11223355", Mem_We_Out, Mem_Wdata_Out); end
    Reset = 1'b0;
    #1;
    checks++; if (Mem_En_Out !== 1'b0 || Mem_We_Out !== 1'b0 || Mem_Addr_Out !== 12'h0 ||
                  Mem_Wdata_Out !== 32'h0) begin errors++;
      $display("FAIL rst_merge_mem_outputs: got %b%b %h %h want 00 000 0",
               Mem_En_Out, Mem_We_Out, Mem_Addr_Out, Mem_Wdata_Out); end
    checks++; if (Cpu_Ack_Out !== 1'b0 || Cpu_Rdata_Out !== 32'h0 || Dma_Rdata_Out !== 32'h0) begin
      errors++;
      $display("FAIL rst_merge_cpu_outputs: got ack=%b %h %h want 0 0 0",
               Cpu_Ack_Out, Cpu_Rdata_Out, Dma_Rdata_Out); end
    @(posedge Clk); @(negedge Clk);
    checks++; if (mem[4] !== 32'h11223344) begin errors++;
      $display("FAIL rst_merge_no_write: got %h want 11223344", mem[4]); end
    Reset = 1'b1;
    cpu_xact(SB, 32'h10, 32'h00000055, lat);
    checks++; if (lat !== 5) begin errors++;
      $display("FAIL rst_release_latency: got %0d want 5", lat); end
    checks++; if (mem[4] !== 32'h11223355) begin errors++;
      $display("FAIL rst_release_mem_word: got %h want 11223355", mem[4]); end
    checks++; if (Cpu_Rdata_Out !== 32'h0) begin errors++;
      $display("FAIL rst_release_rdata: got %h want 0", Cpu_Rdata_Out); end
  endtask

  initial begin
    errors = 0; checks = 0;
    Reset = 1'b0;
    Cpu_Req_In = 1'b0; Cpu_Op_In = 6'b000000; Cpu_Addr_In = 32'h0; Cpu_Wdata_In = 32'h0;
    Dma_Req_In = 1'b0; Dma_We_In = 1'b0; Dma_Addr_In = 32'h0; Dma_Wdata_In = 32'h0;
    pre_en = 1'b0; pre_addr = 12'h0; pre_data = 32'h0;
    @(negedge Clk);
    test_reset();
    test_sw_timing();
    test_byte();
    test_half();
    test_dma();
    test_starvation();
    test_input_hold();
    test_reset_in_merge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
